// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of a single UART transmitter among NumReq
//               byte-stream requesters. The arbiter accepts one byte per grant,
//               latches it, pulses tx_start_o and waits for tx_done_i. It then
//               rotates priority to the requester after the one just served.
// Option      : UART_TX_ARB_LOCK_EN - message lock. While a requester's message
//               is incomplete (its last byte has not been sent), the arbiter
//               serves only that requester.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NumReq    = 2,
    parameter int DataWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic                          tx_start_o,
    output logic [DataWidth-1:0]          tx_data_o,
    input  logic                          tx_busy_i,
    input  logic                          tx_done_i,
    output logic [NumReq-1:0]             grant_o,
    output logic                          busy_o
);

    localparam int PTR_W = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;          // highest-priority requester
    logic [PTR_W-1:0]   owner;        // requester whose byte is in flight
    logic [PTR_W-1:0]   winner;       // combinational pick in Idle
    logic               found;
    logic               accept;
    logic [NumReq-1:0]  eligible;
    logic [DataWidth-1:0] win_data;
    logic [PTR_W-1:0]   ptr_on_done;

    // (base + k) mod NumReq; with a single requester this is always 0.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                   input int k);
        int sum;
        sum = int'(base) + k;
        return PTR_W'(sum % NumReq);
    endfunction

    function automatic logic [NumReq-1:0] onehot(input logic [PTR_W-1:0] sel);
        logic [NumReq-1:0] oh;
        oh = '0;
        for (int i = 0; i < NumReq; i++) begin
            oh[i] = (sel == PTR_W'(i));
        end
        return oh;
    endfunction

`ifdef UART_TX_ARB_LOCK_EN
    logic lock;       // message in progress: only the owner may be served
    logic last_q;     // last flag of the byte in flight

    // While locked, only the owning requester competes.
    always_comb begin
        eligible = req_valid_i;
        if (lock) begin
            eligible = req_valid_i & onehot(owner);
        end
    end

    // An unfinished message keeps the pointer on its owner.
    always_comb begin
        ptr_on_done = last_q ? wrap_add(owner, 1) : owner;
    end

    // Lock bookkeeping: capture last on accept, update lock on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept) begin
                last_q <= |(req_last_i & onehot(winner));
            end
            if (state == ST_WAIT && tx_done_i) begin
                lock <= ~last_q;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last_i;

    // Every requester competes for every byte.
    always_comb begin
        eligible = req_valid_i;
    end

    // After a byte completes, the next requester gets top priority.
    always_comb begin
        ptr_on_done = wrap_add(owner, 1);
    end
`endif

    // Scan ptr, ptr+1, ... (mod NumReq) for the first eligible requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && eligible[wrap_add(ptr, k)]) begin
                found  = 1'b1;
                winner = wrap_add(ptr, k);
            end
        end
    end

    // Select the winner's byte with constant slices.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (winner == PTR_W'(i)) begin
                win_data = req_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    assign accept = found && !tx_busy_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next  = state;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
        grant_o     = '0;
        busy_o      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_o = onehot(winner);
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_start_o = 1'b1;
                grant_o    = onehot(owner);
                busy_o     = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                grant_o = onehot(owner);
                busy_o  = 1'b1;
                if (tx_done_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch byte and owner on accept, rotate pointer on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= '0;
            owner     <= '0;
            tx_data_o <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                owner     <= winner;
                tx_data_o <= win_data;
            end
            if (state == ST_WAIT && tx_done_i) begin
                ptr <= ptr_on_done;
            end
        end
    end

endmodule
`default_nettype wire
